// File: rtl/mips_ctrl_pkg.sv
// Shared control-bundle types for the MIPS pipeline controller.
package mips_ctrl_pkg;

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       bne;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding select for one source register; MEM result beats WB result.
module fwd_unit
    import mips_ctrl_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_regwrite_m,
    input  logic [4:0] i_writereg_m,
    input  logic       i_regwrite_w,
    input  logic [4:0] i_writereg_w,
    output fwd_sel_e   o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_src != 5'd0 && i_regwrite_m && i_writereg_m == i_src) begin
            o_sel = FWD_MEM;
        end else if (i_src != 5'd0 && i_regwrite_w && i_writereg_w == i_src) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Carries the decoded control bundle ID->EX->MEM->WB and resolves load-use,
// branch, jump and data-memory-wait hazards into stall/flush controls.
module pipe_ctrl_unit
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [9:0]       id_ctrl,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_zero,
    input  logic             mem_wait,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             pcsrc_e,
    output logic             jump_d,
    output logic             ex_alusrc,
    output logic             ex_regdst,
    output logic [1:0]       ex_aluop,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             mem_memwrite,
    output logic [4:0]       mem_writereg,
    output logic [4:0]       wb_writereg,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_t            w_id_ctrl;
    logic             r_valid_e, r_valid_m, r_valid_w;
    ctrl_t            r_ctrl_e, r_ctrl_m, r_ctrl_w;
    logic [4:0]       r_rs_e, r_rt_e, r_rd_e;
    logic [4:0]       r_writereg_m, r_writereg_w;
    logic [4:0]       w_writereg_e;
    logic             w_branch_hit, w_load_use, w_jump_req;
    fwd_sel_e         w_fwd_a, w_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_unused;

    assign w_id_ctrl    = ctrl_t'(id_ctrl);
    assign w_writereg_e = r_ctrl_e.regdst ? r_rd_e : r_rt_e;

    assign w_branch_hit = r_valid_e &
                          ((r_ctrl_e.branch & ex_zero) | (r_ctrl_e.bne & ~ex_zero));
    assign w_load_use   = r_valid_e & r_ctrl_e.memtoreg & id_valid & (r_rt_e != 5'd0) &
                          ((r_rt_e == id_rs) | (r_rt_e == id_rt));
    assign w_jump_req   = id_valid & w_id_ctrl.jump;

    // Priority: mem_wait > taken branch > load-use > jump
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        pcsrc_e = 1'b0;
        jump_d  = 1'b0;
        if (mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (w_branch_hit) begin
            pcsrc_e = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (w_load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (w_jump_req) begin
            jump_d  = 1'b1;
            flush_d = 1'b1;
        end
    end

    fwd_unit u_fwd_a (
        .i_src        (r_rs_e),
        .i_regwrite_m (r_valid_m & r_ctrl_m.regwrite),
        .i_writereg_m (r_writereg_m),
        .i_regwrite_w (r_valid_w & r_ctrl_w.regwrite),
        .i_writereg_w (r_writereg_w),
        .o_sel        (w_fwd_a)
    );

    fwd_unit u_fwd_b (
        .i_src        (r_rt_e),
        .i_regwrite_m (r_valid_m & r_ctrl_m.regwrite),
        .i_writereg_m (r_writereg_m),
        .i_regwrite_w (r_valid_w & r_ctrl_w.regwrite),
        .i_writereg_w (r_writereg_w),
        .o_sel        (w_fwd_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_e    <= 1'b0;
            r_ctrl_e     <= CTRL_BUBBLE;
            r_rs_e       <= '0;
            r_rt_e       <= '0;
            r_rd_e       <= '0;
            r_valid_m    <= 1'b0;
            r_ctrl_m     <= CTRL_BUBBLE;
            r_writereg_m <= '0;
            r_valid_w    <= 1'b0;
            r_ctrl_w     <= CTRL_BUBBLE;
            r_writereg_w <= '0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (mem_wait) begin
                // E and M hold; the store/load in M must not retire twice
                r_valid_w    <= 1'b0;
                r_ctrl_w     <= CTRL_BUBBLE;
                r_writereg_w <= '0;
            end else begin
                r_valid_w    <= r_valid_m;
                r_ctrl_w     <= r_ctrl_m;
                r_writereg_w <= r_writereg_m;
                r_valid_m    <= r_valid_e;
                r_ctrl_m     <= r_ctrl_e;
                r_writereg_m <= w_writereg_e;
                if (flush_e || !id_valid) begin
                    r_valid_e <= 1'b0;
                    r_ctrl_e  <= CTRL_BUBBLE;
                    r_rs_e    <= '0;
                    r_rt_e    <= '0;
                    r_rd_e    <= '0;
                end else begin
                    r_valid_e <= 1'b1;
                    r_ctrl_e  <= w_id_ctrl;
                    r_rs_e    <= id_rs;
                    r_rt_e    <= id_rt;
                    r_rd_e    <= id_rd;
                end
            end
            if (stall_f && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if ((flush_d || flush_e) && r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign ex_alusrc    = r_ctrl_e.alusrc;
    assign ex_regdst    = r_ctrl_e.regdst;
    assign ex_aluop     = r_ctrl_e.aluop;
    assign fwd_a_e      = w_fwd_a;
    assign fwd_b_e      = w_fwd_b;
    assign mem_memwrite = r_valid_m & r_ctrl_m.memwrite;
    assign mem_writereg = r_writereg_m;
    assign wb_writereg  = r_writereg_w;
    assign wb_regwrite  = r_valid_w & r_ctrl_w.regwrite;
    assign wb_memtoreg  = r_valid_w & r_ctrl_w.memtoreg;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

    assign w_unused = ^{r_ctrl_w.regdst, r_ctrl_w.alusrc, r_ctrl_w.branch, r_ctrl_w.bne,
                        r_ctrl_w.memwrite, r_ctrl_w.jump, r_ctrl_w.aluop};

endmodule
